// File: rtl/btn_debounce_pkg.sv
// Shared constants for the pushbutton conditioning path (12 MHz iCEBreaker defaults).
// Autorepeat defaults are only used when BTN_AUTOREPEAT_EN is defined.
package btn_debounce_pkg;

    localparam int CLK_HZ                  = 12000000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
    localparam int DEFAULT_HOLD_CYCLES     = CLK_HZ / 2;    // 500 ms before the first repeat
    localparam int DEFAULT_REPEAT_CYCLES   = CLK_HZ / 10;   // 100 ms between repeats

    // BTN_N is the only active-low button on the board.
    localparam logic [3:0] DEFAULT_ACTIVE_LOW_MASK = 4'b1000;

    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: polarity fix, 2-flop synchroniser, stability counter, edge pulses.
// Defining BTN_AUTOREPEAT_EN adds a hold counter that emits repeated press pulses.
module debounce_channel
    import btn_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int   HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int   REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
    parameter logic ACTIVE_LOW      = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic state_o,
    output logic press_o,
    output logic release_o
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 || HOLD_CYCLES < REPEAT_CYCLES) begin : g_bad_cfg
        $error("debounce_channel: invalid cycle parameters");
    end

    logic             pin_n;
    logic             s1_q, s2_q;
    logic             state_q, state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise, fall;

    assign pin_n = pin_i ^ ACTIVE_LOW;

    // The state only flips after an unbroken run of DEBOUNCE_CYCLES mismatches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (s2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            state_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign rise = state_d & ~state_q;
    assign fall = ~state_d & state_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int                HOLD_W      = cnt_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - REPEAT_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              repeat_hit;

    // Reloading to HOLD-REPEAT makes every later repeat REPEAT_CYCLES apart without wrapping.
    always_comb begin
        hold_d     = hold_q;
        repeat_hit = 1'b0;
        if (!state_q) begin
            hold_d = '0;
        end else if (hold_q == HOLD_MAX) begin
            hold_d     = HOLD_RELOAD;
            repeat_hit = state_d;
        end else begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign press_d = rise | repeat_hit;
`else
    assign press_d = rise;
`endif

    assign release_d = fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= pin_n;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Conditions NUM_BTN raw pushbutton pins into debounced levels and press/release pulses.
// Defining BTN_AUTOREPEAT_EN adds autorepeat press pulses while a button is held.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int                 NUM_BTN         = 4,
    parameter int                 DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = NUM_BTN'(DEFAULT_ACTIVE_LOW_MASK),
    parameter int                 HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int                 REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
        ) u_ch (
            .clk_i     (CLK),
            .rst_i     (RST),
            .pin_i     (btn_in[i]),
            .state_o   (btn_state[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i])
        );
    end

endmodule
